// File: rtl/float_to_linear.sv
// Decodes the compact sign/exponent/mantissa format back to a two's-complement
// linear sample, using one left shift of the mantissa per clock.
module float_to_linear #(
    parameter int OUT_W = 12,
    parameter int F_W   = 4,
    parameter int E_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             S,
    input  logic [E_W-1:0]   E,
    input  logic [F_W-1:0]   F,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] D_out,
    output logic             norm_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [OUT_W-1:0] mag;
    logic [E_W-1:0]   cnt;
    logic             sign;
    logic             nerr;

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)    state_nxt = SHIFT;
            SHIFT:   if (cnt == '0)   state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag       <= '0;
            cnt       <= '0;
            sign      <= 1'b0;
            nerr      <= 1'b0;
            D_out     <= '0;
            norm_err  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign <= S;
                        mag  <= OUT_W'(F);
                        cnt  <= E;
                        nerr <= (E != '0) && !F[F_W-1];
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        mag <= mag << 1;
                        cnt <= cnt - 1'b1;
                    end else begin
                        // negative zero falls out naturally: ~0 + 1 wraps to 0
                        D_out     <= sign ? (~mag + OUT_W'(1)) : mag;
                        norm_err  <= nerr;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_linear.sv
// Self-checking bench for float_to_linear: vector table plus random vectors
// through a scoreboard, then backpressure and asynchronous-reset sequences.
module tb_float_to_linear;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] D_out;
    logic        norm_err;

    float_to_linear #(.OUT_W(12), .F_W(4), .E_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .S(S), .E(E), .F(F),
        .out_valid(out_valid), .out_ready(out_ready),
        .D_out(D_out), .norm_err(norm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [2:0]  e;
        logic [3:0]  f;
        logic [11:0] d;
        logic        ne;
    } vec_t;

    typedef struct {
        logic [11:0] d;
        logic        ne;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic s, input logic [2:0] e, input logic [3:0] f);
        vec_t v;
        logic [11:0] m;
        m    = {8'b0, f} << e;
        v.s  = s;
        v.e  = e;
        v.f  = f;
        v.d  = s ? (12'd0 - m) : m;
        v.ne = (e != 3'd0) && !f[3];
        return v;
    endfunction

    // Accept one vector, push its expectation, wait for the result with a bounded
    // wait, compare it against the scoreboard and measure latency.
    task automatic run_vec(input vec_t v, input logic rdy);
        int   edges;
        exp_t x;
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        S         = v.s;
        E         = v.e;
        F         = v.f;
        out_ready = rdy;
        @(posedge clk);
        sb.push_back('{d: v.d, ne: v.ne});
        #1;
        check("in_ready_after_accept", in_ready, 0);
        // busy-time input changes must be ignored
        in_valid = 1'b1;
        S        = ~v.s;
        E        = ~v.e;
        F        = ~v.f;
        edges    = 0;
        do begin
            @(posedge clk);
            edges++;
            #1;
        end while (!out_valid && edges < 20);
        in_valid = 1'b0;
        if (!out_valid) begin
            check("result_timeout", 0, 1);
        end else begin
            check("latency", edges, v.e + 1);
            if (sb.size() == 0) begin
                check("scoreboard_nonempty", 0, 1);
            end else begin
                x = sb.pop_front();
                check("D_out", D_out, x.d);
                check("norm_err", norm_err, x.ne);
            end
        end
    endtask

    task automatic finish_handshake();
        @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
    endtask

    vec_t vecs[7];
    vec_t v;

    initial begin
        vecs[0] = '{s: 1'b0, e: 3'd0, f: 4'b0000, d: 12'h000, ne: 1'b0};
        vecs[1] = '{s: 1'b0, e: 3'd3, f: 4'b1011, d: 12'h058, ne: 1'b0};
        vecs[2] = '{s: 1'b1, e: 3'd7, f: 4'b1111, d: 12'h880, ne: 1'b0};
        vecs[3] = '{s: 1'b0, e: 3'd7, f: 4'b1111, d: 12'h780, ne: 1'b0};
        vecs[4] = '{s: 1'b1, e: 3'd0, f: 4'b0000, d: 12'h000, ne: 1'b0};
        vecs[5] = '{s: 1'b0, e: 3'd2, f: 4'b0101, d: 12'h014, ne: 1'b1};
        vecs[6] = '{s: 1'b1, e: 3'd2, f: 4'b0101, d: 12'hFEC, ne: 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        S         = 1'b0;
        E         = '0;
        F         = '0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_D_out", D_out, 0);
        check("rst_norm_err", norm_err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], 1'b1);
            finish_handshake();
        end

        for (int i = 0; i < 10; i++) begin
            v = model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            run_vec(v, 1'b1);
            finish_handshake();
        end

        // Backpressure: result must hold while in_valid toggles with new data.
        run_vec('{s: 1'b0, e: 3'd1, f: 4'b1000, d: 12'h010, ne: 1'b0}, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            S        = 1'b1;
            E        = 3'd5;
            F        = 4'b1111;
            @(posedge clk);
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_D_out", D_out, 12'h010);
            check("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_D_out_kept", D_out, 12'h010);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_phantom_accept", out_valid, 0);
        check("bp_still_idle", in_ready, 1);

        // Asynchronous reset mid-SHIFT aborts and discards the conversion.
        @(negedge clk);
        in_valid = 1'b1;
        S        = 1'b1;
        E        = 3'd7;
        F        = 4'b1100;
        @(posedge clk);
        sb.push_back('{d: 12'hA00, ne: 1'b0});
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("arst_out_valid", out_valid, 0);
        check("arst_D_out", D_out, 0);
        check("arst_norm_err", norm_err, 0);
        check("arst_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{s: 1'b0, e: 3'd4, f: 4'b1001, d: 12'h090, ne: 1'b0}, 1'b1);
        finish_handshake();
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
